// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults and FSM state type for the I2S transmitter.
package i2s_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_BIT_DIV = 16;
  typedef enum logic [1:0] {IDLE, DELAY, SHIFT} state_t;
endpackage

// File: rtl/i2s_slot_timer.sv
// i2s_slot_timer: bit-slot counter, sclk generation and slot-boundary strobe.
module i2s_slot_timer #(
  parameter int BIT_DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic sclk,
  output logic slot_start
);
  localparam int CW = $clog2(BIT_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (restart || cnt_q == CW'(BIT_DIV - 1)) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign sclk = cnt_q >= CW'(BIT_DIV / 2);
  // High on the last cycle of a slot, so registered state lands on the next slot's first cycle.
  assign slot_start = cnt_q == CW'(BIT_DIV - 1);
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S serial transmitter with one-pair holding register and underrun flag.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BIT_DIV = DEF_BIT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lrclk,
  input  logic [WIDTH-1:0] sample_l,
  input  logic [WIDTH-1:0] sample_r,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             lrclk_out,
  output logic             underrun
);
  localparam int BW = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d, hold_l_q, hold_l_d, hold_r_q, hold_r_d, work_r_q, work_r_d;
  logic lrclk_q, lrclk_d, full_q, full_d, under_q, under_d;
  logic edge_det, fall, rise, xfer, slot_start, shift_en;
  assign edge_det = lrclk != lrclk_q;
  assign fall = edge_det && lrclk_q;
  assign rise = edge_det && !lrclk_q;
  assign xfer = sample_valid && !full_q;
  assign shift_en = state_q == SHIFT && slot_start;
  i2s_slot_timer #(.BIT_DIV(BIT_DIV)) u_timer (
    .clk(clk),
    .rst(rst),
    .restart(edge_det),
    .sclk(sclk),
    .slot_start(slot_start)
  );
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = edge_det ? DELAY :
              !slot_start ? state_q :
              state_q == DELAY ? SHIFT :
              (state_q == SHIFT && bit_q == BW'(WIDTH - 1)) ? IDLE : state_q;
  always_comb begin
    lrclk_d = lrclk;
    bit_d = edge_det ? '0 : shift_en ? bit_q + 1'b1 : bit_q;
    // A pair arriving on the frame-start cycle bypasses the holding register.
    sh_d = fall ? (full_q ? hold_l_q : xfer ? sample_l : '0) :
           rise ? work_r_q : shift_en ? sh_q << 1 : sh_q;
    work_r_d = fall ? (full_q ? hold_r_q : xfer ? sample_r : '0) : work_r_q;
    full_d = fall ? 1'b0 : xfer ? 1'b1 : full_q;
    hold_l_d = xfer ? sample_l : hold_l_q;
    hold_r_d = xfer ? sample_r : hold_r_q;
    under_d = fall && !full_q && !xfer;
  end
  always_ff @(posedge clk)
    if (rst) begin
      lrclk_q <= 1'b0;
      bit_q <= '0;
      sh_q <= '0;
      work_r_q <= '0;
      full_q <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      under_q <= 1'b0;
    end else begin
      lrclk_q <= lrclk_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      work_r_q <= work_r_d;
      full_q <= full_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      under_q <= under_d;
    end
  always_comb sdata = state_q == SHIFT && sh_q[WIDTH-1];
  assign lrclk_out = lrclk_q;
  assign sample_ready = !full_q;
  assign underrun = under_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench; frame words predicted from I2S rules, checked by a serial monitor.
module tb_i2s_tx;
  logic clk = 1'b0;
  logic rst, lrclk, sample_valid, sample_ready, sclk, sdata, lrclk_out, underrun;
  logic [15:0] sample_l, sample_r;
  typedef struct {logic [15:0] w; int u;} item_t;
  item_t sb[$];
  item_t cur;
  int checks = 0, errors = 0, under_cnt = 0, exp_under = 0, n = 0;
  logic active = 1'b0, prev_lr = 1'b0, held = 1'b0;
  logic [15:0] hold_l = '0, hold_r = '0, work_r = '0;

  i2s_tx #(.WIDTH(16), .BIT_DIV(16)) dut (
    .clk(clk), .rst(rst), .lrclk(lrclk), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sclk(sclk),
    .sdata(sdata), .lrclk_out(lrclk_out), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Right half then left half; mode 0 = no pair, 1 = pair loaded early, 2 = pair on the edge cycle.
  task automatic frame_pair(input int mode, input logic [15:0] l, input logic [15:0] r,
                            input int rlen, input int llen);
    logic [15:0] lw;
    lrclk = 1'b1;
    sb.push_back('{work_r, exp_under});
    cyc(10);
    if (mode == 1) begin
      chk("ready_offer", sample_ready, !held);
      sample_valid = 1'b1; sample_l = l; sample_r = r;
      held = 1'b1; hold_l = l; hold_r = r;
    end
    cyc(1);
    sample_valid = 1'b0;
    cyc(rlen - 11);
    chk("ready_pre_fall", sample_ready, !held);
    if (held) begin
      lw = hold_l; work_r = hold_r; held = 1'b0;
    end else if (mode == 2) begin
      lw = l; work_r = r;
    end else begin
      lw = '0; work_r = '0; exp_under++;
    end
    sb.push_back('{lw, exp_under});
    lrclk = 1'b0;
    if (mode == 2) begin
      sample_valid = 1'b1; sample_l = l; sample_r = r;
    end
    cyc(1);
    sample_valid = 1'b0;
    if (mode == 2) chk("ready_after_edge_xfer", sample_ready, 1'b1);
    cyc(llen - 1);
  endtask

  always @(negedge clk) begin
    if (!rst && underrun === 1'b1) under_cnt++;
    if (rst) active = 1'b0;
    else if (lrclk_out !== prev_lr) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame_start: frame seen with no expected word queued at t=%0t", $time);
        active = 1'b0;
      end else begin
        cur = sb.pop_front();
        active = 1'b1;
        n = 0;
      end
    end
    prev_lr = lrclk_out;
    if (active) begin
      if (n % 16 == 0 || n % 16 == 15)
        chk("sdata", sdata, (n >= 16 && n < 272) ? cur.w[15 - (n / 16 - 1)] : 1'b0);
      if (n % 8 == 0 || n % 8 == 7) chk("sclk", sclk, (n % 16) >= 8);
      if (n == 16) chk_int("underrun_count", under_cnt, cur.u);
      n++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; lrclk = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
    cyc(3);
    chk("reset_ready", sample_ready, 1'b1);
    chk("reset_sdata", sdata, 1'b0);
    chk("reset_sclk", sclk, 1'b0);
    chk("reset_lrclk_out", lrclk_out, 1'b0);
    chk("reset_underrun", underrun, 1'b0);
    rst = 1'b0;
    cyc(5);
    frame_pair(1, 16'hA5F0, 16'h0F0F, 513, 513);
    frame_pair(0, 16'h1234, 16'h5678, 513, 513);
    frame_pair(2, 16'h8001, 16'h7FFE, 513, 513);
    frame_pair(1, 16'($urandom), 16'($urandom), 513, 200);
    for (int i = 0; i < 8; i++)
      frame_pair(int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 513, 513);
    frame_pair(1, 16'hC3A5, 16'h5A3C, 513, 150);
    rst = 1'b1;
    cyc(1);
    chk("midframe_reset_sdata", sdata, 1'b0);
    chk("midframe_reset_ready", sample_ready, 1'b1);
    chk("midframe_reset_sclk", sclk, 1'b0);
    cyc(2);
    rst = 1'b0;
    held = 1'b0; work_r = '0; sb.delete();
    cyc(20);
    frame_pair(1, 16'hFFFF, 16'h0001, 513, 513);
    frame_pair(0, 16'h0, 16'h0, 513, 513);
    frame_pair(2, 16'($urandom), 16'($urandom), 513, 513);
    lrclk = 1'b1;
    sb.push_back('{work_r, exp_under});
    cyc(513);
    chk_int("queue_drained", sb.size(), 0);
    chk_int("underrun_total", under_cnt, exp_under);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter WIDTH, default 16, sample width in bits per channel.
REQ-002 Parameter BIT_DIV, default 16, clk cycles per serial bit slot; even, >= 4.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 lrclk  input  1  word-select from the LR clock divider, synchronous to clk; 0 = left, 1 = right.
REQ-006 sample_l  input  WIDTH  left sample, two's complement.
REQ-007 sample_r  input  WIDTH  right sample, two's complement.
REQ-008 sample_valid  input  1  sample_l/sample_r valid.
REQ-009 sample_ready  output  1  holding register empty; a pair transfers on the cycle where valid and ready are both 1.
REQ-010 sclk  output  1  serial bit clock to the DAC.
REQ-011 sdata  output  1  serial data to the DAC, MSB first.
REQ-012 lrclk_out  output  1  word-select to the DAC, aligned with sclk/sdata.
REQ-013 underrun  output  1  one-cycle pulse when a frame starts with no sample pair held.

Function
REQ-014 lrclk registered once into lrclk_q; an edge is detected on the cycle lrclk != lrclk_q; lrclk_out = lrclk_q.
REQ-015 Slot counter 0..BIT_DIV-1 free-runs, wraps to 0, and is forced to 0 on the cycle after each detected edge.
REQ-016 sclk = 0 while slot counter < BIT_DIV/2, 1 otherwise; sdata changes only when the slot counter is 0.
REQ-017 FSM states IDLE, DELAY, SHIFT; any detected edge -> DELAY, bit counter cleared.
REQ-018 DELAY lasts exactly one slot with sdata = 0 (I2S one-bit delay), then -> SHIFT.
REQ-019 SHIFT drives sdata with bit WIDTH-1 down to bit 0, one bit per slot; after WIDTH slots -> IDLE.
REQ-020 IDLE drives sdata = 0 until the next detected edge.
REQ-021 Falling edge (left frame start): held pair moves to the working pair, holding register marked empty, shift register loaded with the left word.
REQ-022 Rising edge: shift register loaded with the working right word; no holding-register access.
REQ-023 Falling edge with holding register empty: working pair cleared to 0, underrun pulses for that cycle, left and right frames transmit zeros.
REQ-024 Transfer and falling edge on the same cycle: incoming pair is used for the starting frame, holding register stays empty, no underrun.
REQ-025 Edge during SHIFT: remaining bits abandoned, new frame begins per REQ-017; no error flag.
REQ-026 Latency: MSB on sdata at the BIT_DIV+1 th cycle after the lrclk edge detection cycle.
REQ-027 Requirement on the system: (WIDTH+1)*BIT_DIV <= LR half-period in clk cycles (513 with the existing divider).

Reset
REQ-028 rst: sclk 0, sdata 0, lrclk_out 0, lrclk_q 0, sample_ready 1, underrun 0, state IDLE, counters 0, working pair 0.
REQ-029 rst mid-frame aborts the frame; the first frame after reset starts at the next detected edge.

Structure
REQ-030 Package i2s_pkg holds WIDTH and BIT_DIV defaults and the FSM state type.
REQ-031 One sub-module, i2s_slot_timer: the slot counter, sclk generation and the slot-start strobe.

Verification
REQ-032 Reset: rst high for 3 cycles -> sample_ready 1, sdata 0, sclk 0.
REQ-033 Load L=16'hA5F0, R=16'h0F0F before a falling edge -> after the DELAY slot, sdata shows 1010010111110000; after the rising edge, 0000111100001111; each bit held 16 cycles.
REQ-034 No sample loaded at a falling edge -> underrun pulses once, 34 slots of sdata 0, sample_ready stays 1.
REQ-035 Valid asserted on the falling-edge detection cycle with L=16'h8001 -> that frame sends 8001, no underrun, sample_ready 1 the next cycle.
REQ-036 rst pulsed at bit 7 of the left word -> sdata 0 immediately; transmission resumes correctly from the next edge.
REQ-037 Free-running lrclk period 1026 -> sclk period exactly 16 cycles, zero phase at every frame start.
